tune_sequencer: RTL and testbench

TUNE_SEQUENCER -- requirements
Module: tune_sequencer

---
 rtl/tune_sequencer.sv | 177 +++++++++++++++++
 tb/tb_tune_sequencer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tune_sequencer.sv
// Tuning run sequencer: loads a solver-proposed current into the DAC, waits for it to settle,
// measures Q, hands the result to the solver and repeats until convergence or a failure cause.
module tune_sequencer #(
    parameter int BUS_WIDTH     = 10,
    parameter int SETTLE_CYCLES = 16,
    parameter int MAX_ITER      = 32,
    parameter int MEAS_TIMEOUT  = 255
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [BUS_WIDTH-1:0]          q_target,
    input  logic [BUS_WIDTH-1:0]          solver_i_ref,
    input  logic                          solver_converged,
    input  logic                          solver_unstable,
    input  logic [BUS_WIDTH-1:0]          meas_q,
    input  logic                          meas_done,
    output logic                          solver_rst,
    output logic                          solver_ready,
    output logic [BUS_WIDTH-1:0]          q_desired,
    output logic [BUS_WIDTH-1:0]          q_measured,
    output logic                          dac_load,
    output logic [BUS_WIDTH-1:0]          dac_code,
    output logic                          meas_start,
    output logic                          busy,
    output logic                          done,
    output logic                          fail,
    output logic [1:0]                    fail_code,
    output logic [$clog2(MAX_ITER+1)-1:0] iter_count
);

    localparam int IW = $clog2(MAX_ITER + 1);
    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int WW = (MEAS_TIMEOUT > 0) ? $clog2(MEAS_TIMEOUT + 1) : 1;

    typedef enum logic [2:0] {IDLE, INIT, LOAD, SETTLE, MEASURE, HANDOFF, CHECK, FINISH} state_t;

    state_t               state, state_nxt;
    logic [SW-1:0]        settle_cnt, settle_cnt_nxt;
    logic [WW-1:0]        wdog_cnt, wdog_cnt_nxt;
    logic                 check_wait, check_wait_nxt;
    logic [BUS_WIDTH-1:0] q_desired_nxt, q_measured_nxt, dac_code_nxt;
    logic                 solver_rst_nxt, solver_ready_nxt, dac_load_nxt, meas_start_nxt;
    logic                 busy_nxt, done_nxt, fail_nxt;
    logic [1:0]           fail_code_nxt;
    logic [IW-1:0]        iter_count_nxt;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            settle_cnt   <= '0;
            wdog_cnt     <= '0;
            check_wait   <= 1'b0;
            q_desired    <= '0;
            q_measured   <= '0;
            dac_code     <= '0;
            solver_rst   <= 1'b0;
            solver_ready <= 1'b0;
            dac_load     <= 1'b0;
            meas_start   <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            fail         <= 1'b0;
            fail_code    <= 2'b00;
            iter_count   <= '0;
        end else begin
            state        <= state_nxt;
            settle_cnt   <= settle_cnt_nxt;
            wdog_cnt     <= wdog_cnt_nxt;
            check_wait   <= check_wait_nxt;
            q_desired    <= q_desired_nxt;
            q_measured   <= q_measured_nxt;
            dac_code     <= dac_code_nxt;
            solver_rst   <= solver_rst_nxt;
            solver_ready <= solver_ready_nxt;
            dac_load     <= dac_load_nxt;
            meas_start   <= meas_start_nxt;
            busy         <= busy_nxt;
            done         <= done_nxt;
            fail         <= fail_nxt;
            fail_code    <= fail_code_nxt;
            iter_count   <= iter_count_nxt;
        end
    end

    always_comb begin
        // NOTE: every signal gets a default here first so no path can infer a latch.
        state_nxt        = state;
        settle_cnt_nxt   = settle_cnt;
        wdog_cnt_nxt     = wdog_cnt;
        check_wait_nxt   = check_wait;
        q_desired_nxt    = q_desired;
        q_measured_nxt   = q_measured;
        dac_code_nxt     = dac_code;
        busy_nxt         = busy;
        fail_code_nxt    = fail_code;
        iter_count_nxt   = iter_count;
        solver_rst_nxt   = 1'b0;
        solver_ready_nxt = 1'b0;
        dac_load_nxt     = 1'b0;
        meas_start_nxt   = 1'b0;
        done_nxt         = 1'b0;
        fail_nxt         = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt      = INIT;
                    q_desired_nxt  = q_target;
                    iter_count_nxt = '0;
                    fail_code_nxt  = 2'b00;
                    busy_nxt       = 1'b1;
                    solver_rst_nxt = 1'b1;
                end
            end
            INIT: state_nxt = LOAD;
            LOAD: begin
                dac_code_nxt   = solver_i_ref;
                dac_load_nxt   = 1'b1;
                settle_cnt_nxt = SW'(SETTLE_CYCLES - 1);
                state_nxt      = SETTLE;
            end
            SETTLE: begin
                if (settle_cnt == '0) begin
                    state_nxt      = MEASURE;
                    meas_start_nxt = 1'b1;
                    wdog_cnt_nxt   = '0;
                end else begin
                    settle_cnt_nxt = settle_cnt - 1'b1;
                end
            end
            MEASURE: begin
                wdog_cnt_nxt = wdog_cnt + 1'b1;
                // meas_start is high only in the first MEASURE cycle, when meas_done is not yet trusted.
                if (!meas_start && meas_done) begin
                    q_measured_nxt   = meas_q;
                    solver_ready_nxt = 1'b1;
                    state_nxt        = HANDOFF;
                end else if (wdog_cnt == WW'(MEAS_TIMEOUT)) begin
                    state_nxt     = FINISH;
                    busy_nxt      = 1'b0;
                    fail_nxt      = 1'b1;
                    fail_code_nxt = 2'b11;
                end
            end
            HANDOFF: begin
                if (iter_count != IW'(MAX_ITER)) iter_count_nxt = iter_count + 1'b1;
                check_wait_nxt = 1'b1;
                state_nxt      = CHECK;
            end
            CHECK: begin
                if (check_wait) begin
                    check_wait_nxt = 1'b0;
                end else begin
                    state_nxt = FINISH;
                    busy_nxt  = 1'b0;
                    if (solver_unstable) begin
                        fail_nxt      = 1'b1;
                        fail_code_nxt = 2'b01;
                    end else if (solver_converged) begin
                        done_nxt = 1'b1;
                    end else if (iter_count == IW'(MAX_ITER)) begin
                        fail_nxt      = 1'b1;
                        fail_code_nxt = 2'b10;
                    end else begin
                        state_nxt = LOAD;
                        busy_nxt  = 1'b1;
                    end
                end
            end
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_tune_sequencer.sv
// Randomized bench for tune_sequencer: solver and measurement models drive the DUT while an
// arithmetic run model predicts outcome, iteration count and start-to-finish latency.
module tb_tune_sequencer;

    localparam int BW     = 10;
    localparam int SETTLE = 16;
    localparam int MAXI   = 32;
    localparam int TMO    = 255;
    localparam int IW     = $clog2(MAXI + 1);
    localparam int BUDGET = 4000;

    typedef struct {
        bit is_fail;
        int code;
        int iters;
        int latency;
        int loads;
        int readies;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [BW-1:0] q_target;
    logic [BW-1:0] solver_i_ref;
    logic          solver_converged;
    logic          solver_unstable;
    logic [BW-1:0] meas_q;
    logic          meas_done;
    logic          solver_rst;
    logic          solver_ready;
    logic [BW-1:0] q_desired;
    logic [BW-1:0] q_measured;
    logic          dac_load;
    logic [BW-1:0] dac_code;
    logic          meas_start;
    logic          busy;
    logic          done;
    logic          fail;
    logic [1:0]    fail_code;
    logic [IW-1:0] iter_count;

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [BW-1:0] props [0:MAXI];
    int            meas_dly [1:MAXI];
    int            ks;
    logic [BW-1:0] drv_mq;

    tune_sequencer #(
        .BUS_WIDTH(BW), .SETTLE_CYCLES(SETTLE), .MAX_ITER(MAXI), .MEAS_TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .q_target(q_target),
        .solver_i_ref(solver_i_ref), .solver_converged(solver_converged),
        .solver_unstable(solver_unstable), .meas_q(meas_q), .meas_done(meas_done),
        .solver_rst(solver_rst), .solver_ready(solver_ready), .q_desired(q_desired),
        .q_measured(q_measured), .dac_load(dac_load), .dac_code(dac_code),
        .meas_start(meas_start), .busy(busy), .done(done), .fail(fail),
        .fail_code(fail_code), .iter_count(iter_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Run outcome from the iteration rules: each pass costs LOAD + settle + measure + handoff + check.
    function automatic exp_t predict(input int conv_it, input int unst_it, input int tmo_it);
        exp_t e;
        int   t;
        e = '{default: 0};
        t = 1;
        for (int k = 1; k <= MAXI; k++) begin
            e.loads = k;
            t += 1 + SETTLE;
            if (k == tmo_it) begin
                e.is_fail = 1; e.code = 3; e.iters = k - 1; e.latency = t + TMO + 1;
                return e;
            end
            t += 1 + meas_dly[k] + 1 + 2;
            e.readies = k; e.iters = k; e.latency = t;
            if (unst_it != 0 && k >= unst_it) begin e.is_fail = 1; e.code = 1; return e; end
            if (conv_it != 0 && k >= conv_it) return e;
            if (k == MAXI) begin e.is_fail = 1; e.code = 2; return e; end
        end
        return e;
    endfunction

    task automatic run_case(input string name, input int tgt, input int conv_it, input int unst_it,
                            input int tmo_it, input bit stray, input bit spur, input int first_dly);
        exp_t e;
        int   cyc, loads, readies, last_load, last_ms, end_cyc, meas_wait;
        bit   ended, meas_pend;
        for (int k = 0; k <= MAXI; k++) props[k] = BW'($urandom);
        for (int k = 1; k <= MAXI; k++) meas_dly[k] = $urandom_range(1, 6);
        if (first_dly != 0) meas_dly[1] = first_dly;
        e = predict(conv_it, unst_it, tmo_it);
        cyc = 0; loads = 0; readies = 0; last_load = 0; last_ms = 0; end_cyc = 0;
        meas_wait = 0; ended = 0; meas_pend = 0;

        start = 1'b1; q_target = BW'(tgt);
        @(posedge clk); #1;
        start = 1'b0;
        check({name, "/start_busy"}, int'(busy), 1);
        check({name, "/init_solver_rst"}, int'(solver_rst), 1);
        check({name, "/start_q_desired"}, int'(q_desired), tgt);

        while (!ended && cyc < BUDGET) begin
            if (dac_load) begin
                check({name, "/dac_code"}, int'(dac_code), (loads <= MAXI) ? int'(props[loads]) : -1);
                check({name, "/busy_in_run"}, int'(busy), 1);
                loads++;
                last_load = cyc;
            end
            if (meas_start) begin
                check({name, "/settle_len"}, cyc - last_load, SETTLE);
                last_ms = cyc;
            end
            if (solver_ready) begin
                check({name, "/q_measured"}, int'(q_measured), int'(drv_mq));
                readies++;
            end
            if (done || fail) begin
                ended   = 1;
                end_cyc = cyc;
            end

            start     = 1'b0;
            meas_done = 1'b0;
            if (meas_pend) begin
                meas_wait--;
                if (meas_wait == 0) begin
                    meas_done = 1'b1; meas_q = BW'($urandom); drv_mq = meas_q; meas_pend = 0;
                end
            end
            if (meas_start) begin
                if (loads != tmo_it) begin
                    meas_pend = 1;
                    meas_wait = (loads >= 1 && loads <= MAXI) ? meas_dly[loads] : 1;
                end
                if (spur) begin meas_done = 1'b1; meas_q = BW'($urandom); end
                if (stray && loads == 2) begin start = 1'b1; q_target = BW'(40); end
            end
            if (solver_rst) begin
                ks = 0; solver_i_ref = props[0]; solver_converged = 1'b0; solver_unstable = 1'b0;
            end
            if (solver_ready) begin
                if (ks < MAXI) ks++;
                solver_i_ref     = props[ks];
                solver_converged = (conv_it != 0 && ks >= conv_it);
                solver_unstable  = (unst_it != 0 && ks >= unst_it);
            end
            if (!ended) begin
                @(posedge clk); #1;
                cyc++;
            end
        end

        check({name, "/run_ended"}, int'(ended), 1);
        if (!ended) begin
            @(negedge clk) rst = 1'b1;
            @(negedge clk) rst = 1'b0;
            @(posedge clk); #1;
            return;
        end
        check({name, "/done"}, int'(done), e.is_fail ? 0 : 1);
        check({name, "/fail"}, int'(fail), e.is_fail ? 1 : 0);
        check({name, "/fail_code"}, int'(fail_code), e.code);
        check({name, "/iter_count"}, int'(iter_count), e.iters);
        check({name, "/latency"}, end_cyc, e.latency);
        check({name, "/busy_at_end"}, int'(busy), 0);
        check({name, "/dac_loads"}, loads, e.loads);
        check({name, "/solver_readies"}, readies, e.readies);
        check({name, "/q_desired_held"}, int'(q_desired), tgt);
        check({name, "/dac_code_held"}, int'(dac_code), int'(props[e.loads - 1]));
        if (readies > 0) check({name, "/q_measured_held"}, int'(q_measured), int'(drv_mq));
        if (e.code == 3) check({name, "/timeout_len"}, end_cyc - last_ms, TMO + 1);

        // A start in the FINISH cycle must be dropped.
        start = 1'b1; q_target = ~BW'(tgt);
        @(posedge clk); #1;
        start = 1'b0;
        check({name, "/finish_start_busy"}, int'(busy), 0);
        check({name, "/finish_start_rst"}, int'(solver_rst), 0);
        check({name, "/pulse_cleared"}, int'(done | fail), 0);
        check({name, "/fail_code_hold"}, int'(fail_code), e.code);
        check({name, "/q_desired_idle"}, int'(q_desired), tgt);
    endtask

    task automatic reset_mid_run();
        solver_i_ref = BW'(5);
        start = 1'b1; q_target = BW'(77);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #3;
        check("midrst/pre_busy", int'(busy), 1);
        rst = 1'b1;
        #1;
        check("midrst/buses_zero", int'({q_desired, q_measured, dac_code}), 0);
        check("midrst/ctrl_zero", int'({solver_rst, solver_ready, dac_load, meas_start, busy,
                                        done, fail, fail_code, iter_count}), 0);
        drv_mq = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("midrst/no_pulse", int'(done | fail | busy), 0);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation exceeded its time limit");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; start = 1'b0; q_target = '0; solver_i_ref = '0;
        solver_converged = 1'b0; solver_unstable = 1'b0; meas_q = '0; meas_done = 1'b0;
        ks = 0; drv_mq = '0;
        #12;
        check("reset/buses_zero", int'({q_desired, q_measured, dac_code}), 0);
        check("reset/ctrl_zero", int'({solver_rst, solver_ready, dac_load, meas_start, busy,
                                       done, fail, fail_code, iter_count}), 0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;

        run_case("converge3", 110, 3, 0, 0, 1'b1, 1'b0, 0);
        run_case("meas_timeout", 200, 1, 0, 1, 1'b0, 1'b1, 0);
        run_case("iter_limit", 300, 0, 0, 0, 1'b0, 1'b0, 0);
        run_case("both_flags", 512, 2, 2, 0, 1'b0, 1'b1, 0);
        run_case("done_vs_expiry", 9, 1, 0, 0, 1'b0, 1'b0, TMO);
        reset_mid_run();
        run_case("after_reset", 110, 1, 0, 0, 1'b0, 1'b0, 0);
        for (int r = 0; r < 6; r++) begin
            run_case($sformatf("rand%0d", r), $urandom_range(0, 1023), $urandom_range(1, 6),
                     ($urandom_range(0, 2) == 0) ? $urandom_range(1, 6) : 0,
                     ($urandom_range(0, 4) == 0) ? $urandom_range(1, 3) : 0,
                     1'b0, 1'($urandom_range(0, 1)), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
